// File: rtl/md_pkg.sv
// md_pkg: op encoding, default latencies and FSM states shared by the multiply/divide unit
package md_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational HI/LO result for mult/multu/div/divu, holding HI/LO on divide-by-zero
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n
);
  logic [63:0] ps, pu;
  logic [31:0] bd, qs, rs, qu, ru;
  logic dz, ovf, is_div;
  assign dz = b == 32'd0;
  assign ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign is_div = op == MD_DIV || op == MD_DIVU;
  // safe divisor keeps the dividers away from x/0 and INT_MIN/-1
  assign bd = (dz || ovf) ? 32'd1 : b;
  assign ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign pu = {32'd0, a} * {32'd0, b};
  assign qs = $signed(a) / $signed(bd);
  assign rs = $signed(a) % $signed(bd);
  assign qu = a / bd;
  assign ru = a % bd;
  always_comb begin
    {hi_n, lo_n} = op == MD_MULT  ? ps :
                   op == MD_MULTU ? pu :
                   (is_div && dz) ? {hi, lo} :
                   op == MD_DIV   ? (ovf ? {32'd0, a} : {rs, qs}) :
                   op == MD_DIVU  ? {ru, qu} : {hi, lo};
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer with HI/LO registers and D-stage stall request
module mdu_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_SrcA,
  input  logic [31:0] E_SrcB,
  input  logic        D_MDUUse,
  output logic [31:0] E_MDOut,
  output logic        busy,
  output logic        start,
  output logic        md_stall
);
  md_state_t state, state_n;
  logic [3:0] cnt, op_q;
  logic [31:0] a_q, b_q, hi, lo, hi_n, lo_n;
  logic is_long, is_mul;
  assign is_long = E_MDUOp >= MD_MULT && E_MDUOp <= MD_DIVU;
  assign is_mul = E_MDUOp == MD_MULT || E_MDUOp == MD_MULTU;
  assign busy = state == BUSY;
  assign start = is_long && !busy;
  assign md_stall = D_MDUUse && (start || busy);
  assign E_MDOut = E_MDUOp == MD_MFHI ? hi : E_MDUOp == MD_MFLO ? lo : 32'd0;
  md_calc u_calc (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (hi),
    .lo   (lo),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );
  always_comb begin
    state_n = state;
    if (start) state_n = BUSY;
    if (busy && cnt == 4'd1) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= MD_NONE;
      a_q <= '0;
      b_q <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        op_q <= E_MDUOp;
        a_q <= E_SrcA;
        b_q <= E_SrcB;
        cnt <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (busy) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi <= hi_n;
          lo <= lo_n;
        end
      end else begin
        if (E_MDUOp == MD_MTHI) hi <= E_SrcA;
        if (E_MDUOp == MD_MTLO) lo <= E_SrcA;
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl latency, arithmetic, stall and reset behaviour
module tb_mdu_ctrl;
  import md_pkg::*;
  typedef struct packed {logic [31:0] hi; logic [31:0] lo;} res_t;
  logic clk = 0, reset = 1, D_MDUUse = 0;
  logic [3:0] E_MDUOp = MD_NONE;
  logic [31:0] E_SrcA = 0, E_SrcB = 0, E_MDOut;
  logic busy, start, md_stall;
  res_t exp_q[$];
  int n_checks = 0, n_fail = 0;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDUOp  (E_MDUOp),
    .E_SrcA   (E_SrcA),
    .E_SrcB   (E_SrcB),
    .D_MDUUse (D_MDUUse),
    .E_MDOut  (E_MDOut),
    .busy     (busy),
    .start    (start),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a long op for one cycle; operands are scrambled afterwards to prove they were latched
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input res_t e, output logic st);
    E_MDUOp = op;
    E_SrcA = a;
    E_SrcB = b;
    exp_q.push_back(e);
    #1 st = start;
    tick();
    E_MDUOp = MD_NONE;
    E_SrcA = $urandom;
    E_SrcB = $urandom;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic readback(output logic [31:0] h, output logic [31:0] l);
    E_MDUOp = MD_MFHI;
    #1 h = E_MDOut;
    E_MDUOp = MD_MFLO;
    #1 l = E_MDOut;
    E_MDUOp = MD_NONE;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1;
    tick();
    tick();
    reset = 0;
    n_checks++;
    if (busy !== 1'b0 || start !== 1'b0 || md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b start=%b stall=%b, required 0 0 0", busy, start, md_stall);
    end
    readback(h, l);
    n_checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h/%h, required 0/0", h, l);
    end
  endtask

  task automatic test_mult();
    logic st;
    int n;
    res_t e;
    logic [31:0] h, l;
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1}, st);
    n_checks++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_start: got %b, required 1", st);
    end
    drain(n);
    n_checks++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL mult_busy_cycles: got %0d, required 5", n);
    end
    e = exp_q.pop_front();
    readback(h, l);
    n_checks++;
    if (h !== e.hi || l !== e.lo) begin
      n_fail++;
      $display("FAIL mult_result: got %h/%h, required %h/%h", h, l, e.hi, e.lo);
    end
  endtask

  task automatic test_multu_div();
    logic st;
    int n;
    res_t e;
    logic [31:0] h, l;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, '{32'h0000_0001, 32'hFFFF_FFFE}, st);
    drain(n);
    e = exp_q.pop_front();
    readback(h, l);
    n_checks++;
    if (n != 5 || h !== e.hi || l !== e.lo) begin
      n_fail++;
      $display("FAIL multu: cycles %0d result %h/%h, required 5 %h/%h", n, h, l, e.hi, e.lo);
    end
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD}, st);
    drain(n);
    e = exp_q.pop_front();
    readback(h, l);
    n_checks++;
    if (n != 10 || h !== e.hi || l !== e.lo) begin
      n_fail++;
      $display("FAIL div_signed: cycles %0d result %h/%h, required 10 %h/%h", n, h, l, e.hi, e.lo);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    res_t e;
    E_MDUOp = MD_DIV;
    E_SrcA = 32'd100;
    E_SrcB = 32'd7;
    D_MDUUse = 1;
    exp_q.push_back('{32'd2, 32'd14});
    #1;
    n_checks++;
    if (md_stall !== 1'b1 || start !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_at_start: stall=%b start=%b, required 1 1", md_stall, start);
    end
    tick();
    E_MDUOp = MD_NONE;
    for (int i = 1; i <= 10; i++) begin
      if (md_stall !== 1'b1) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d cycles without stall, required 0", bad);
    end
    n_checks++;
    if (md_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: stall=%b busy=%b, required 0 0", md_stall, busy);
    end
    D_MDUUse = 0;
    e = exp_q.pop_front();
    E_MDUOp = MD_MFLO;
    #1;
    n_checks++;
    if (E_MDOut !== e.lo) begin
      n_fail++;
      $display("FAIL stall_mflo: got %h, required %h", E_MDOut, e.lo);
    end
    E_MDUOp = MD_NONE;
  endtask

  task automatic test_mthi_divzero();
    logic st;
    int n;
    res_t e;
    logic [31:0] h, l;
    E_MDUOp = MD_MTHI;
    E_SrcA = 32'h0000_1234;
    tick();
    E_MDUOp = MD_MFHI;
    D_MDUUse = 1;
    #1;
    n_checks++;
    if (E_MDOut !== 32'h0000_1234 || busy !== 1'b0 || md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: out=%h busy=%b stall=%b, required 00001234 0 0", E_MDOut, busy, md_stall);
    end
    D_MDUUse = 0;
    issue(MD_DIVU, 32'd55, 32'd0, '{32'h0000_1234, 32'd14}, st);
    drain(n);
    e = exp_q.pop_front();
    readback(h, l);
    n_checks++;
    if (n != 10 || h !== e.hi || l !== e.lo) begin
      n_fail++;
      $display("FAIL divu_zero: cycles %0d result %h/%h, required 10 %h/%h", n, h, l, e.hi, e.lo);
    end
  endtask

  task automatic test_div_edge();
    logic st;
    int n;
    res_t e;
    logic [31:0] h, l;
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{32'd0, 32'h8000_0000}, st);
    drain(n);
    e = exp_q.pop_front();
    readback(h, l);
    n_checks++;
    if (h !== e.hi || l !== e.lo) begin
      n_fail++;
      $display("FAIL div_overflow: got %h/%h, required %h/%h", h, l, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    logic st;
    int n;
    res_t e;
    logic [31:0] h, l;
    issue(MD_MULT, 32'd1000, 32'd1000, '{32'd0, 32'd1000000}, st);
    void'(exp_q.pop_back());
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got %b, required 0", busy);
    end
    readback(h, l);
    n_checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_hilo: got %h/%h, required 0/0", h, l);
    end
    issue(MD_MULTU, 32'd3, 32'd4, '{32'd0, 32'd12}, st);
    E_MDUOp = MD_MTLO;
    E_SrcA = 32'h0000_DEAD;
    tick();
    E_MDUOp = MD_MULT;
    #1;
    n_checks++;
    if (start !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: got %b, required 0", start);
    end
    tick();
    E_MDUOp = MD_NONE;
    drain(n);
    e = exp_q.pop_front();
    readback(h, l);
    n_checks++;
    if (n != 3 || h !== e.hi || l !== e.lo) begin
      n_fail++;
      $display("FAIL ignore_while_busy: cycles %0d result %h/%h, required 3 %h/%h", n, h, l, e.hi, e.lo);
    end
  endtask

  task automatic test_random();
    logic st;
    int n;
    res_t e;
    logic [31:0] a, b, h, l;
    logic [63:0] p;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : ($urandom >> (i * 4)) | 32'd1;
      p = {32'd0, a} * {32'd0, b};
      if (i % 2 == 0) issue(MD_MULTU, a, b, '{p[63:32], p[31:0]}, st);
      else issue(MD_DIVU, a, b, '{a % b, a / b}, st);
      drain(n);
      e = exp_q.pop_front();
      readback(h, l);
      n_checks++;
      if (n != ((i % 2 == 0) ? 5 : 10) || h !== e.hi || l !== e.lo) begin
        n_fail++;
        $display("FAIL random_%0d: cycles %0d result %h/%h, required %h/%h", i, n, h, l, e.hi, e.lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_div();
    test_stall();
    test_mthi_divzero();
    test_div_edge();
    test_reset_mid();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the E stage beside the ALU and runs mult/multu/div/divu and mfhi/mflo/mthi/mtlo.
- Sequences each long operation with a busy counter.
- Raises a stall request so the hazard unit holds PC and D_Reg and bubbles E while an MDU-using instruction in D would otherwise read HI/LO before the result is ready.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- E_MDUOp  in  4  op of the instruction currently in E (md_pkg encoding; MD_NONE for non-MDU or bubble)
- E_SrcA  in  32  forwarded rs value (the same value the ALU sees)
- E_SrcB  in  32  forwarded rt value (pre-immediate mux)
- D_MDUUse  in  1  instruction in D is any MDU op (mult..mtlo)
- E_MDOut  out  32  HI for MFHI, LO for MFLO, else 0; combinational
- busy  out  1  long operation in progress
- start  out  1  combinational; E_MDUOp is MULT/MULTU/DIV/DIVU and busy==0
- md_stall  out  1  combinational; D_MDUUse & (start | busy), ORed into the global stall by the hazard unit

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, busy=0, cnt=0, pending result regs=0. Reset mid-operation cancels the operation with no HI/LO update; busy=0 on the next cycle.
- State machine with two states:
  - IDLE: busy=0.
    - start=1: latch op, E_SrcA, E_SrcB; cnt=MULT_CYCLES or DIV_CYCLES; go to BUSY.
    - MTHI: HI<=E_SrcA at the edge.
    - MTLO: LO<=E_SrcA at the edge.
  - BUSY: busy=1; cnt decrements each cycle.
    - cnt==1: HI/LO <= computed result at that edge, go to IDLE.
- Timing: op in E at cycle t (start=1) gives busy=1 for cycles t+1..t+N, and HI/LO hold the new value from cycle t+N+1.
- An MFHI/MFLO held in D by md_stall enters E at t+N+1 and reads the new value. No extra forwarding is needed.
- Any E_MDUOp arriving while busy=1 is ignored (start=0, no HI/LO write). md_stall prevents this from happening in normal operation.
- MFHI/MFLO never stall inside this block; the stall is raised in D only.
- Arithmetic:
  - MULT: {HI,LO}=signed 32x32 -> 64.
  - MULTU: {HI,LO}=unsigned 32x32 -> 64.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - Divisor 0 (div or divu): runs the full DIV_CYCLES, then HI and LO keep their old values.
- Result computation: combinational from the latched operands, registered only at commit. Operands are latched at start, so a later change on E_SrcA/E_SrcB does not affect the result.
- Simultaneous start and D_MDUUse: md_stall=1 in that same cycle.
- Back-to-back mult then mult: the second is stalled in D until busy drops, then starts in the first IDLE cycle.

Decomposition:
- md_pkg holds:
  - Op constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
  - Default cycle constants 5 and 10.
  - State encoding IDLE=0, BUSY=1.
- One natural sub-module, md_calc: purely combinational. Takes op, a, b, old HI/LO and returns new HI/LO, including the div-by-zero hold and the signed-division rules.
- mdu_ctrl owns the FSM, counter, operand latches and HI/LO.
- MCU adds an MDUOp decode output; D_MDUUse = (D MDUOp != MD_NONE).

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5 at cycle t -> start=1 at t; busy=1 for t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFF1 from t+6; busy=0 at t+6.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. Then DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV at t with D_MDUUse=1 (MFLO in D) from t -> md_stall=1 for t..t+10, 0 at t+11. MFLO in E at t+11 gives E_MDOut = new LO.
- MTHI A=0x00001234 in E while IDLE -> next cycle, with MFHI in E, E_MDOut=0x00001234, busy stays 0, no stall. Then DIVU with B=0 -> 10 busy cycles, HI=0x00001234 and LO unchanged.
- Division edge case: DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Reset during a MULT: MULT start, reset=1 on the 3rd busy cycle -> next cycle busy=0, HI=LO=0, E_MDOut=0. Also an MTLO driven while busy -> ignored, LO unchanged.
